// File: rtl/cache_set_ctrl_if.sv
// Core/memory/bank handshake bundle for cache_set_ctrl.
// master drives requests and acks; slave is the controller.
interface cache_set_ctrl_if #(
    parameter int SET_W = 2,
    parameter int TAG_W = 24
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_hit;
    logic [1:0]       resp_way;

    logic             mem_req;
    logic             mem_wb;
    logic [SET_W-1:0] mem_set;
    logic [TAG_W-1:0] mem_tag;
    logic             mem_ack;

    logic             bank_en;
    logic             bank_we;
    logic [SET_W-1:0] bank_set;
    logic [1:0]       bank_way;

    modport slave (
        input  req_valid, req_write, req_set, req_tag, mem_ack,
        output req_ready, resp_valid, resp_hit, resp_way,
        output mem_req, mem_wb, mem_set, mem_tag,
        output bank_en, bank_we, bank_set, bank_way
    );

    modport master (
        output req_valid, req_write, req_set, req_tag, mem_ack,
        input  req_ready, resp_valid, resp_hit, resp_way,
        input  mem_req, mem_wb, mem_set, mem_tag,
        input  bank_en, bank_we, bank_set, bank_way
    );
endinterface

// File: rtl/cache_set_ctrl.sv
// Tag/state controller for a 4-way set-associative cache.
// Lookup, victim writeback, fill and one bank access per request.
module cache_set_ctrl #(
    parameter int SETS  = 4,
    parameter int SET_W = 2,
    parameter int TAG_W = 24
) (
    input logic              clk,
    input logic              rst_n,
    cache_set_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        ACCESS
    } state_t;

    state_t state_q;

    logic [SETS-1:0][3:0]            valid_q;
    logic [SETS-1:0][3:0]            dirty_q;
    logic [SETS-1:0][3:0][TAG_W-1:0] tags_q;
    logic [SETS-1:0][2:0]            plru_q;

    logic [SET_W-1:0] set_q;
    logic [TAG_W-1:0] tag_q;
    logic             we_q;
    logic             hit_q;
    logic [1:0]       way_q;

    logic       hit_d;
    logic [1:0] hway_d;
    logic [1:0] vway_d;
    logic [2:0] plru_cur;

    assign plru_cur = plru_q[set_q];

    // Tag compare and victim choice for the captured set
    always_comb begin
        hit_d  = 1'b0;
        hway_d = 2'd0;
        vway_d = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                             : (plru_cur[1] ? 2'd1 : 2'd0);
        for (int i = 3; i >= 0; i--) begin
            if (valid_q[set_q][i] && tags_q[set_q][i] == tag_q) begin
                hit_d  = 1'b1;
                hway_d = 2'(i);
            end
            if (!valid_q[set_q][i]) begin
                vway_d = 2'(i);
            end
        end
    end

    // Sequencer plus tag/valid/dirty/PLRU storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            tags_q  <= '0;
            plru_q  <= '0;
            set_q   <= '0;
            tag_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        set_q   <= bus.req_set;
                        tag_q   <= bus.req_tag;
                        we_q    <= bus.req_write;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit_d;
                    way_q <= hit_d ? hway_d : vway_d;
                    if (hit_d) begin
                        state_q <= ACCESS;
                    end else if (valid_q[set_q][vway_d]
                                 && dirty_q[set_q][vway_d]) begin
                        state_q <= WB;
                    end else begin
                        state_q <= FILL;
                    end
                end
                WB: begin
                    if (bus.mem_ack) begin
                        dirty_q[set_q][way_q] <= 1'b0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        tags_q[set_q][way_q]  <= tag_q;
                        valid_q[set_q][way_q] <= 1'b1;
                        dirty_q[set_q][way_q] <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        dirty_q[set_q][way_q] <= 1'b1;
                    end
                    if (!way_q[1]) begin
                        plru_q[set_q][0] <= 1'b1;
                        plru_q[set_q][1] <= (way_q == 2'd0);
                    end else begin
                        plru_q[set_q][0] <= 1'b0;
                        plru_q[set_q][2] <= (way_q == 2'd2);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic in_wb;
    logic in_fill;
    logic in_acc;

    assign in_wb   = (state_q == WB);
    assign in_fill = (state_q == FILL);
    assign in_acc  = (state_q == ACCESS);

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = in_acc;
    assign bus.resp_hit   = in_acc & hit_q;
    assign bus.resp_way   = in_acc ? way_q : 2'd0;

    assign bus.mem_req = in_wb | in_fill;
    assign bus.mem_wb  = in_wb;
    assign bus.mem_set = set_q;
    assign bus.mem_tag = in_wb   ? tags_q[set_q][way_q] :
                         in_fill ? tag_q : '0;

    assign bus.bank_en  = in_acc;
    assign bus.bank_we  = in_acc & we_q;
    assign bus.bank_set = set_q;
    assign bus.bank_way = in_acc ? way_q : 2'd0;
endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl.
// Expected responses and memory phases queued, popped on DUT output.
module tb_cache_set_ctrl;
    logic clk;
    logic rst_n;

    cache_set_ctrl_if #(.SET_W(2), .TAG_W(24)) bus ();

    cache_set_ctrl #(.SETS(4), .SET_W(2), .TAG_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [1:0] way;
        logic       we;
    } resp_t;

    typedef struct packed {
        logic        wb;
        logic [23:0] tag;
    } memx_t;

    resp_t rq[$];
    memx_t mq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(input logic wb, input logic [23:0] t);
        memx_t m;
        m.wb  = wb;
        m.tag = t;
        mq.push_back(m);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_req(input logic w, input logic [1:0] s,
                           input logic [23:0] t, input int ackdly,
                           input bit noise, input logic ehit,
                           input logic [1:0] eway, input int elat);
        resp_t r;
        memx_t m;
        bit    done;
        bit    phase;
        int    wt;
        r.hit = ehit;
        r.way = eway;
        r.we  = w;
        rq.push_back(r);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_set   = s;
        bus.req_tag   = t;
        @(posedge clk);
        @(negedge clk);
        if (!noise) bus.req_valid = 1'b0;
        done  = 1'b0;
        phase = 1'b0;
        wt    = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (noise) begin
                bus.req_write = 1'($urandom);
                bus.req_set   = 2'($urandom);
                bus.req_tag   = 24'($urandom);
            end
            bus.mem_ack = 1'b0;
            chk("ready_busy", 32'(bus.req_ready), 32'd0);
            if (bus.mem_req) begin
                if (!phase) begin
                    phase = 1'b1;
                    wt    = 0;
                    if (mq.size() == 0) begin
                        chk("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
                    end else begin
                        m = mq.pop_front();
                        chk("mem_wb", 32'(bus.mem_wb), 32'(m.wb));
                        chk("mem_tag", 32'(bus.mem_tag), 32'(m.tag));
                        chk("mem_set", 32'(bus.mem_set), 32'(s));
                    end
                end
                if (wt == ackdly) begin
                    bus.mem_ack = 1'b1;
                    phase       = 1'b0;
                end else begin
                    wt++;
                end
            end
            if (bus.resp_valid) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_hit", 32'(bus.resp_hit), 32'(r.hit));
                    chk("resp_way", 32'(bus.resp_way), 32'(r.way));
                    chk("bank_en", 32'(bus.bank_en), 32'd1);
                    chk("bank_we", 32'(bus.bank_we), 32'(r.we));
                    chk("bank_set", 32'(bus.bank_set), 32'(s));
                    chk("bank_way", 32'(bus.bank_way), 32'(r.way));
                    chk("latency", 32'(c), 32'(elat));
                end
                bus.req_valid = 1'b0;
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        chk("resp_seen", 32'(done), 32'd1);
        chk("mem_phases_left", 32'(mq.size()), 32'd0);
        bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_set   = '0;
        bus.req_tag   = '0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_bank_en", 32'(bus.bank_en), 32'd0);
        chk("rst_mem_tag", 32'(bus.mem_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean miss, then hit on the same line
        push_mem(1'b0, 24'h00ABCD);
        run_req(1'b0, 2'd1, 24'h00ABCD, 3, 1'b0, 1'b0, 2'd0, 6);
        run_req(1'b0, 2'd1, 24'h00ABCD, 0, 1'b0, 1'b1, 2'd0, 2);

        // fill set 2, touch way 0, PLRU victim must be way 2
        for (int i = 0; i < 4; i++) begin
            push_mem(1'b0, 24'h10 + 24'(i));
            run_req(1'b0, 2'd2, 24'h10 + 24'(i), 0, 1'b0,
                    1'b0, 2'(i), 3);
        end
        run_req(1'b0, 2'd2, 24'h10, 0, 1'b0, 1'b1, 2'd0, 2);
        push_mem(1'b0, 24'h20);
        run_req(1'b0, 2'd2, 24'h20, 0, 1'b0, 1'b0, 2'd2, 3);

        // dirty line in set 0 evicted with writeback then fill
        push_mem(1'b0, 24'h55);
        run_req(1'b1, 2'd0, 24'h55, 0, 1'b0, 1'b0, 2'd0, 3);
        for (int i = 1; i < 4; i++) begin
            push_mem(1'b0, 24'h55 + 24'(i));
            run_req(1'b0, 2'd0, 24'h55 + 24'(i), 0, 1'b0,
                    1'b0, 2'(i), 3);
        end
        push_mem(1'b1, 24'h55);
        push_mem(1'b0, 24'h59);
        run_req(1'b0, 2'd0, 24'h59, 1, 1'b0, 1'b0, 2'd0, 6);

        // busy-time request noise, captured fields must win
        push_mem(1'b0, 24'h99);
        run_req(1'b1, 2'd1, 24'h99, 2, 1'b1, 1'b0, 2'd1, 5);

        // mem_ack in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'b1;
            @(negedge clk);
            chk("idle_ack_ready", 32'(bus.req_ready), 32'd1);
            chk("idle_ack_memreq", 32'(bus.mem_req), 32'd0);
            chk("idle_ack_resp", 32'(bus.resp_valid), 32'd0);
        end
        bus.mem_ack = 1'b0;
        run_req(1'b0, 2'd1, 24'h99, 0, 1'b0, 1'b1, 2'd1, 2);

        // reset during FILL
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_set   = 2'd3;
        bus.req_tag   = 24'h77;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.mem_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_fill_seen", 32'(seen), 32'd1);
        chk("abort_in_fill", 32'(bus.mem_wb), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
        chk("abort_bank_en", 32'(bus.bank_en), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        push_mem(1'b0, 24'h77);
        run_req(1'b0, 2'd3, 24'h77, 0, 1'b0, 1'b0, 2'd0, 3);
        push_mem(1'b0, 24'h00ABCD);
        run_req(1'b0, 2'd1, 24'h00ABCD, 0, 1'b0, 1'b0, 2'd0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
